// File: rtl/led_pkg.sv
// Shared constants for the four-digit LED driver.
// Hex-to-segment table, anode select patterns, output bundle.
package led_pkg;

  typedef logic [3:0] hex_t;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] an_t;

  // an = {an3, an2, an1, an0}, seg = {a..g}; all active-low
  typedef struct packed {
    an_t  an;
    seg_t seg;
    logic dp;
  } led_out_t;

  localparam an_t  AN_OFF  = 4'b1111;
  localparam seg_t SEG_OFF = 7'b1111111;

  // Indexed by phase: digit 3 is scanned first
  localparam an_t AN_SEL [4] = '{
    4'b0111,
    4'b1011,
    4'b1101,
    4'b1110
  };

  localparam seg_t SEG_LUT [16] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100,
    7'b0001000,
    7'b1100000,
    7'b0110001,
    7'b1000010,
    7'b0110000,
    7'b0111000
  };

  localparam led_out_t OUT_RST = '{
    an:  AN_OFF,
    seg: SEG_OFF,
    dp:  1'b1
  };

  function automatic seg_t hex2seg(
    input hex_t v
  );
    return SEG_LUT[v];
  endfunction

endpackage

// File: rtl/led_decoder.sv
// Combinational hex-to-7-segment decoder.
// Ports: hex (4-bit value in), seg (abcdefg, active-low out).
module led_decoder
  import led_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    seg = hex2seg(hex);
  end

endmodule

// File: rtl/four_digit_led_driver.sv
// Multiplexed 4-digit 7-segment driver with anode dead-time.
// Ports: clk, reset (sync, active-low), an3..an0, a..g, dp.
module four_digit_led_driver
  import led_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 4,
  parameter logic [3:0]  DIGIT3    = 4'h0,
  parameter logic [3:0]  DIGIT2    = 4'h1,
  parameter logic [3:0]  DIGIT1    = 4'h2,
  parameter logic [3:0]  DIGIT0    = 4'h3
) (
  input  logic clk,
  input  logic reset,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  localparam int unsigned SW = DIV_WIDTH - 2;

  logic [DIV_WIDTH-1:0] cnt;
  logic [1:0]           phase;
  logic [SW-1:0]        sub;
  logic                 sub_first;
  logic                 dead;
  hex_t                 sel_hex;
  seg_t                 sel_seg;
  led_out_t             out_d;
  led_out_t             out_q;

  assign phase     = cnt[DIV_WIDTH-1 -: 2];
  assign sub       = cnt[SW-1:0];
  assign sub_first = (sub == '0);
  // First and last slot of each phase keep all
  // anodes dark so digit changes never ghost.
  assign dead      = sub_first || (&sub);

  always_comb begin
    sel_hex = DIGIT3;
    unique case (1'b1)
      (phase == 2'd0): sel_hex = DIGIT3;
      (phase == 2'd1): sel_hex = DIGIT2;
      (phase == 2'd2): sel_hex = DIGIT1;
      (phase == 2'd3): sel_hex = DIGIT0;
    endcase
  end

  led_decoder u_dec (
    .hex (sel_hex),
    .seg (sel_seg)
  );

  // Segments latch at the phase start and hold,
  // so they settle before the anode opens.
  always_comb begin
    out_d    = out_q;
    out_d.dp = 1'b1;
    out_d.an = dead ? AN_OFF : AN_SEL[phase];
    if (sub_first) begin
      out_d.seg = sel_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      out_q <= OUT_RST;
    end else begin
      cnt   <= cnt + 1'b1;
      out_q <= out_d;
    end
  end

  assign {an3, an2, an1, an0}   = out_q.an;
  assign {a, b, c, d, e, f, g}  = out_q.seg;
  assign dp                     = out_q.dp;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Self-checking bench for four_digit_led_driver.
// Two instances: default digits and A/b/C/F digits.
`timescale 1ns/1ps
module tb_four_digit_led_driver;

  logic clk;
  logic reset;

  logic a_an3, a_an2, a_an1, a_an0;
  logic a_a, a_b, a_c, a_d, a_e, a_f, a_g, a_dp;
  logic b_an3, b_an2, b_an1, b_an0;
  logic b_a, b_b, b_c, b_d, b_e, b_f, b_g, b_dp;

  int vectors;
  int miscompares;

  four_digit_led_driver u_a (
    .clk   (clk),
    .reset (reset),
    .an3   (a_an3),
    .an2   (a_an2),
    .an1   (a_an1),
    .an0   (a_an0),
    .a     (a_a),
    .b     (a_b),
    .c     (a_c),
    .d     (a_d),
    .e     (a_e),
    .f     (a_f),
    .g     (a_g),
    .dp    (a_dp)
  );

  four_digit_led_driver #(
    .DIV_WIDTH (4),
    .DIGIT3    (4'hA),
    .DIGIT2    (4'hB),
    .DIGIT1    (4'hC),
    .DIGIT0    (4'hF)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .an3   (b_an3),
    .an2   (b_an2),
    .an1   (b_an1),
    .an0   (b_an0),
    .a     (b_a),
    .b     (b_b),
    .c     (b_c),
    .d     (b_d),
    .e     (b_e),
    .f     (b_f),
    .g     (b_g),
    .dp    (b_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] an_a, an_b;
  logic [6:0] sg_a, sg_b;
  assign an_a = {a_an3, a_an2, a_an1, a_an0};
  assign an_b = {b_an3, b_an2, b_an1, b_an0};
  assign sg_a = {a_a, a_b, a_c, a_d, a_e, a_f, a_g};
  assign sg_b = {b_a, b_b, b_c, b_d, b_e, b_f, b_g};

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(
    input string       name,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b",
               name, $time, got, exp);
    end
  endtask

  // Model: outputs after an edge are a function of
  // the refresh position held before that edge.
  int digits_a [4] = '{0, 1, 2, 3};
  int digits_b [4] = '{10, 11, 12, 15};
  int         mpos;
  logic       mvalid = 1'b0;
  logic [3:0] e_an;
  logic [6:0] e_sa, e_sb;

  always @(posedge clk) begin
    if (!reset) begin
      mpos   <= 0;
      mvalid <= 1'b1;
      e_an   <= 4'b1111;
      e_sa   <= 7'b1111111;
      e_sb   <= 7'b1111111;
    end else if (mvalid) begin
      if ((mpos % 4) == 1 || (mpos % 4) == 2)
        e_an <= ~(4'b1000 >> (mpos / 4));
      else
        e_an <= 4'b1111;
      e_sa <= seg_of(digits_a[mpos / 4]);
      e_sb <= seg_of(digits_b[mpos / 4]);
      mpos <= (mpos + 1) % 16;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      chk("a_an",  16'(an_a), 16'(e_an));
      chk("a_seg", 16'(sg_a), 16'(e_sa));
      chk("a_dp",  16'(a_dp), 16'd1);
      chk("b_an",  16'(an_b), 16'(e_an));
      chk("b_seg", 16'(sg_b), 16'(e_sb));
      chk("b_dp",  16'(b_dp), 16'd1);
      chk("a_onehot",
          16'($countones(~an_a) <= 1), 16'd1);
    end
  end

  int  k;
  int  lows;
  bit  found;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;

    repeat (15) begin
      @(posedge clk);
      #1;
      chk("rst_an", 16'(an_a), 16'hf);
      chk("rst_seg", 16'(sg_b), 16'h7f);
    end

    @(negedge clk);
    reset = 1'b1;
    for (k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      case (k)
        1:  chk("k1_an",  16'(an_a), 16'b1111);
        2:  chk("k2_an",  16'(an_a), 16'b0111);
        3:  chk("k3_seg", 16'(sg_a), 16'b0000001);
        4:  chk("k4_an",  16'(an_a), 16'b1111);
        6:  chk("k6_seg", 16'(sg_a), 16'b1001111);
        7:  chk("k7_an",  16'(an_a), 16'b1011);
        10: chk("k10_seg", 16'(sg_a), 16'b0010010);
        11: chk("k11_an", 16'(an_a), 16'b1101);
        14: chk("k14_an", 16'(an_a), 16'b1110);
        15: chk("k15_seg", 16'(sg_a), 16'b0000110);
        18: chk("k18_an", 16'(an_a), 16'b0111);
        19: chk("b19_seg", 16'(sg_b), 16'b0001000);
        22: chk("b22_seg", 16'(sg_b), 16'b1100000);
        27: chk("b27_seg", 16'(sg_b), 16'b0110001);
        30: chk("b30_seg", 16'(sg_b), 16'b0111000);
        default: ;
      endcase
    end

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (an_a == 4'b1011) found = 1'b1;
    end
    chk("wait_an2", 16'(found), 16'd1);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_an", 16'(an_a), 16'b1111);
    chk("mid_rst_seg", 16'(sg_a), 16'h7f);
    @(negedge clk);
    reset = 1'b1;

    found = 1'b0;
    lows  = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (an_a != 4'b1111) begin
        found = 1'b1;
        lows  = i;
        chk("first_an", 16'(an_a), 16'b0111);
      end
    end
    chk("first_found", 16'(found), 16'd1);
    chk("first_cycle", 16'(lows), 16'd2);

    repeat (20) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
